// File: rtl/tt_um_islam_ihfaz_2_1_mux_pkg.sv
// Shared definitions for the tt_um_islam_ihfaz_2_1_mux tile.
// Contents: select-mode encoding, uio_in field positions, the constant
// uio_oe pattern and a small parity helper used for the Y parity flag.
package tt_um_islam_ihfaz_2_1_mux_pkg;

    // Select-source modes carried on uio_in[2:1]
    typedef enum logic [1:0] {
        MODE_EXT     = 2'b00,
        MODE_FORCE_A = 2'b01,
        MODE_FORCE_B = 2'b10,
        MODE_TOGGLE  = 2'b11
    } mode_e;

    // Field positions inside uio_in
    localparam int unsigned EXT_SEL_BIT = 0;
    localparam int unsigned MODE_LO_BIT = 1;
    localparam int unsigned MODE_HI_BIT = 2;
    localparam int unsigned HOLD_BIT    = 3;

    // Upper nibble of uio is driven (counter), lower nibble is input (control)
    localparam logic [7:0] UIO_OE_VAL = 8'hF0;

    // Even-parity bit (XOR reduction) of a 4-bit word
    function automatic logic parity4(input logic [3:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/tt_um_islam_ihfaz_2_1_mux_mux_sel_ctrl.sv
// Select-source control for the 2:1 mux.
// Ports:
//   mode    in  2  select-source mode (EXT / FORCE_A / FORCE_B / TOGGLE)
//   ext_sel in  1  externally supplied select (0 = A, 1 = B)
//   sel_q   in  1  currently registered select
//   sel_n   out 1  select to be used on the next loaded edge
module mux_sel_ctrl
    import tt_um_islam_ihfaz_2_1_mux_pkg::*;
(
    input  mode_e mode,
    input  logic  ext_sel,
    input  logic  sel_q,
    output logic  sel_n
);

    // Pick the next select; TOGGLE inverts the registered value so it
    // alternates on every loaded edge and starts with B after reset.
    always_comb begin
        sel_n = 1'b0;
        case (mode)
            MODE_EXT:     sel_n = ext_sel;
            MODE_FORCE_A: sel_n = 1'b0;
            MODE_FORCE_B: sel_n = 1'b1;
            MODE_TOGGLE:  sel_n = ~sel_q;
            default:      sel_n = 1'b0;
        endcase
    end

endmodule

// File: rtl/tt_um_islam_ihfaz_2_1_mux.sv
// TinyTapeout tile: registered 4-bit 2:1 multiplexer with select-source
// modes, hold control, status flags and a select-switch counter.
// Ports:
//   clk     in  1  design clock, rising edge
//   rst_n   in  1  asynchronous reset, ACTIVE-HIGH despite the harness name
//   ena     in  1  tile enable; 0 holds state like the hold bit
//   ui_in   in  8  [3:0] data A, [7:4] data B
//   uio_in  in  8  [0] ext select, [2:1] mode, [3] hold, [7:4] unused
//   uo_out  out 8  [3:0] Y, [4] sel_q, [5] parity(Y), [6] Y==0, [7] changed
//   uio_out out 8  [3:0] zero, [7:4] switch counter
//   uio_oe  out 8  constant 8'hF0
module tt_um_islam_ihfaz_2_1_mux
    import tt_um_islam_ihfaz_2_1_mux_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [3:0] y_q;
    logic       sel_q;
    logic       chg_q;
    logic [3:0] cnt_q;

    logic       load;
    logic       sel_n;
    logic [3:0] y_n;
    mode_e      mode;
    logic       unused_bits;

    assign mode        = mode_e'(uio_in[MODE_HI_BIT:MODE_LO_BIT]);
    assign load        = ena & ~uio_in[HOLD_BIT];
    assign unused_bits = ^uio_in[7:4];

    mux_sel_ctrl u_sel_ctrl (
        .mode    (mode),
        .ext_sel (uio_in[EXT_SEL_BIT]),
        .sel_q   (sel_q),
        .sel_n   (sel_n)
    );

    assign y_n = sel_n ? ui_in[7:4] : ui_in[3:0];

    // Datapath, select, change flag and switch counter; the change flag is a
    // one-cycle pulse, so it clears on any non-loaded edge.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            y_q   <= 4'h0;
            sel_q <= 1'b0;
            chg_q <= 1'b0;
            cnt_q <= 4'h0;
        end else if (load) begin
            y_q   <= y_n;
            sel_q <= sel_n;
            chg_q <= (y_n != y_q);
            cnt_q <= cnt_q + {3'b000, (sel_n != sel_q)};
        end else begin
            chg_q <= 1'b0;
        end
    end

    // Flags are decoded from flops only, so outputs stay glitch-free
    assign uo_out  = {chg_q, (y_q == 4'h0), parity4(y_q), sel_q, y_q};
    assign uio_out = {cnt_q, 4'h0};
    assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_islam_ihfaz_2_1_mux.sv
// Self-checking bench for tt_um_islam_ihfaz_2_1_mux: directed steps with a
// behavioural reference model feeding a scoreboard queue of expected outputs.
module tb_tt_um_islam_ihfaz_2_1_mux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [3:0] m_y;
    logic       m_sel;
    logic       m_chg;
    logic [3:0] m_cnt;

    logic [15:0] sb[$];

    tt_um_islam_ihfaz_2_1_mux dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_y   = 4'h0;
        m_sel = 1'b0;
        m_chg = 1'b0;
        m_cnt = 4'h0;
    endtask

    function automatic logic [15:0] model_out();
        return {m_chg, (m_y == 4'h0), ^m_y, m_sel, m_y, m_cnt, 4'h0};
    endfunction

    // Apply inputs (away from the edge), predict, clock once, compare.
    task automatic step(input logic [7:0] ui, input logic [7:0] uio, input logic en,
                        input string tag);
        logic       sel_next;
        logic [3:0] y_next;
        logic [15:0] exp;
        ui_in  = ui;
        uio_in = uio;
        ena    = en;
        if (en && !uio[3]) begin
            case (uio[2:1])
                2'b00:   sel_next = uio[0];
                2'b01:   sel_next = 1'b0;
                2'b10:   sel_next = 1'b1;
                default: sel_next = ~m_sel;
            endcase
            y_next = sel_next ? ui[7:4] : ui[3:0];
            m_chg  = (y_next != m_y);
            m_cnt  = m_cnt + ((sel_next != m_sel) ? 4'd1 : 4'd0);
            m_y    = y_next;
            m_sel  = sel_next;
        end else begin
            m_chg = 1'b0;
        end
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'h0000, 16'hFFFF);
        end else begin
            exp = sb.pop_front();
            chk(tag, {uo_out, uio_out}, exp);
        end
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic pulse_reset(input string tag);
        rst_n = 1'b1;
        model_reset();
        #1;
        chk({tag, "_out"}, {uo_out, uio_out}, 16'h4000);
        chk({tag, "_oe"}, {8'h00, uio_oe}, 16'h00F0);
        rst_n = 1'b0;
    endtask

    initial begin
        // Reset with no clock edge yet
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'hA5;
        uio_in = 8'h00;
        model_reset();
        #2;
        chk("reset_uo", {8'h00, uo_out}, 16'h0040);
        chk("reset_uio", {8'h00, uio_out}, 16'h0000);
        chk("reset_oe", {8'h00, uio_oe}, 16'h00F0);
        rst_n = 1'b0;

        // EXT mode
        step(8'h3C, 8'h00, 1'b1, "ext_a");
        chk("ext_a_const", {8'h00, uo_out}, 16'h008C);
        step(8'h3C, 8'h01, 1'b1, "ext_b");
        chk("ext_b_const", {uo_out, uio_out}, 16'h9310);

        // FORCE_B then FORCE_A
        step(8'h70, 8'h04, 1'b1, "force_b");
        chk("force_b_const", {8'h00, uo_out}, 16'h00B7);
        step(8'h70, 8'h02, 1'b1, "force_a");
        chk("force_a_const", {uo_out, uio_out}, 16'hC020);

        // Hold via uio_in[3], via ena=0, and both together
        step(8'hFF, 8'h09, 1'b1, "hold_bit");
        chk("hold_bit_const", {uo_out, uio_out}, 16'h4020);
        step(8'hAB, 8'h05, 1'b0, "hold_ena");
        step(8'h12, 8'h0F, 1'b0, "hold_both");

        // Mid-operation async reset, then TOGGLE from reset
        pulse_reset("reset_mid");
        for (int i = 0; i < 4; i++) step(8'h21, 8'h06, 1'b1, "toggle");
        chk("toggle_cnt4", {8'h00, uio_out}, 16'h0040);
        for (int i = 0; i < 16; i++) step(8'h21, 8'h06, 1'b1, "toggle_wrap");
        chk("toggle_wrap_cnt", {8'h00, uio_out}, 16'h0040);
        // Mode change mid-stream takes effect on the next edge
        step(8'h21, 8'h04, 1'b1, "mode_switch");

        // Same value on both inputs: select flips but Y is unchanged
        pulse_reset("reset_same");
        step(8'h55, 8'h00, 1'b1, "same_a");
        step(8'h55, 8'h01, 1'b1, "same_b");
        chk("same_b_const", {uo_out, uio_out}, 16'h1510);

        // A few pseudo-random loaded/held cycles
        for (int i = 0; i < 24; i++)
            step(8'($urandom), {4'h0, 4'($urandom)}, 1'($urandom_range(0, 3) != 0), "random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_um_islam_ihfaz_2_1_mux.md
Name: tt_um_islam_ihfaz_2_1_mux

Overview:
- TinyTapeout user tile implementing a registered 4-bit 2:1 multiplexer with selectable select-source modes, hold control, status flags and a select-switch counter.
- Sits directly behind the standard TT pad harness: dedicated inputs carry both data words, bidirectional pins carry control (in) and counter (out).
- All outputs come from flops; one-cycle latency.

Parameters:
- none; widths fixed by the TT harness (8-bit ui/uo/uio).

Ports:
- clk  in  1  single design clock; all state updates on rising edge.
- rst_n  in  1  asynchronous reset, active-high: 1 clears all state immediately; 0 = run. Name kept for harness compatibility.
- ena  in  1  tile enable; 0 = hold all state (same as hold bit).
- ui_in  in  8  [3:0] data A, [7:4] data B.
- uio_in  in  8  [0] external select (0=A, 1=B), [2:1] mode, [3] hold, [7:4] ignored.
- uo_out  out  8  [3:0] Y, [4] sel_q, [5] parity of Y, [6] Y zero flag, [7] changed flag.
- uio_out  out  8  [3:0] always 0, [7:4] switch counter.
- uio_oe  out  8  constant 8'hF0 (upper nibble driven, lower nibble input), independent of reset.

Behaviour:
- State: y_q[3:0], sel_q, chg_q, cnt_q[3:0]. Reset (rst_n=1, async): all 0, so uo_out=8'h40 (zero flag set), uio_out=8'h00.
- load = ena & ~uio_in[3]. load=0: y_q, sel_q, cnt_q hold; chg_q <= 0.
- Effective select sel_n by mode uio_in[2:1]: 00 EXT = uio_in[0]; 01 FORCE_A = 0; 10 FORCE_B = 1; 11 TOGGLE = ~sel_q (alternates every loaded cycle, starts with B after reset).
- On loaded edge: y_q <= sel_n ? ui_in[7:4] : ui_in[3:0]; sel_q <= sel_n; chg_q <= (new y != y_q); cnt_q <= cnt_q + (sel_n != sel_q), wrapping 15->0.
- Latency: input change visible on uo_out after exactly one rising edge.
- Combinational outputs from flops only: uo_out[5] = ^y_q; uo_out[6] = (y_q == 0).
- Mode change mid-stream takes effect on the next edge; no glitch state.
- Reset asserted mid-operation clears immediately without waiting for clk; first edge after release behaves as a normal loaded edge.
- Hold and ena=0 are equivalent; both asserted = hold.

Decomposition:
- Package: mode constants MODE_EXT=2'b00, MODE_FORCE_A=2'b01, MODE_FORCE_B=2'b10, MODE_TOGGLE=2'b11; bit-index constants for uio_in fields; UIO_OE_VAL=8'hF0.
- One sub-module mux_sel_ctrl: combinational, inputs mode, ext_sel, sel_q; output sel_n. Top holds the data path, flags and counter.

Test Plan:
- Reset: rst_n=1 with ui_in=8'hA5 -> uo_out=8'h40, uio_out=8'h00, uio_oe=8'hF0 without a clock edge.
- EXT mode: ui_in=8'h3C, uio_in=8'h00, one edge -> uo_out[3:0]=4'hC; set uio_in[0]=1, edge -> Y=4'h3, sel_q=1, cnt=1, changed=1, parity=0.
- FORCE_B then FORCE_A: ui_in=8'h70, mode 10 -> Y=4'h7, parity=1; mode 01 -> Y=4'h0, zero flag=1, changed=1.
- TOGGLE: ui_in=8'h21, mode 11, 4 edges from reset -> Y sequence 2,1,2,1; cnt=4; 16 further toggles -> cnt wraps to 4.
- Hold: set uio_in[3]=1 (or ena=0), change ui_in and select -> Y, sel_q, cnt unchanged; changed flag 0 after one edge.
- Same value reload: EXT mode, A=B=4'h5, flip select -> Y stays 5, changed=0, cnt increments.
